nr_div_result_fixup: RTL and testbench

//  Downstream stage of the non-restoring divider. Takes the unsigned quotient/remainder

---
 rtl/nr_div_pkg.sv | 17 +
 rtl/nr_div_fifo2.sv | 53 +++++
 rtl/nr_div_result_fixup.sv | 92 +++++++++
 tb/tb_nr_div_result_fixup.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nr_div_pkg.sv
// Shared definitions for the non-restoring divider result path.
// Width-agnostic so every divider width can import the same package.
package nr_div_pkg;

    localparam int unsigned DIV_N_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;

    // Result-flag vector layout.
    localparam int unsigned FLAG_OVF = 0;
    localparam int unsigned FLAG_DZ  = 1;
    localparam int unsigned FLAG_W   = 2;

    // Saturated quotient is {1'b0, ones}; users slice the low N-1 bits.
    localparam int unsigned    SAT_MAX_W    = 64;
    localparam logic [SAT_MAX_W-1:0] QUO_SAT_ONES = '1;

endpackage

// File: rtl/nr_div_fifo2.sv
// Generic two-entry register FIFO with valid/ready on both sides.
// Head entry is read straight from storage, so pop data is glitch-free.
module nr_div_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // Ready depends only on the stored count, never on pop_ready.
    assign push_ready = (count != 2'd2);
    assign pop_valid  = (count != 2'd0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nr_div_result_fixup.sv
// Divider output stage: sign/zero fixup of core magnitudes, overflow saturation,
// divide-by-zero flagging, error counting and a 2-entry output FIFO.
module nr_div_result_fixup
    import nr_div_pkg::*;
#(
    parameter int unsigned N     = DIV_N_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_quo,
    input  logic [N-1:0]     in_rem,
    input  logic [N-1:0]     in_dd,
    input  logic             in_dd_neg,
    input  logic             in_dr_neg,
    input  logic             in_dr_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_quo,
    output logic [N-1:0]     out_rem,
    output logic             out_dz,
    output logic             out_ovf,
    output logic [CNT_W-1:0] err_cnt
);

    typedef struct packed {
        logic [N-1:0]      quo;
        logic [N-1:0]      rem;
        logic [FLAG_W-1:0] flags;
    } div_result_t;

    localparam int unsigned RES_W = $bits(div_result_t);
    localparam logic [N-1:0] QUO_SAT = {1'b0, QUO_SAT_ONES[N-2:0]};

    div_result_t fix;
    div_result_t head;
    logic        neg;
    logic        accept;
    logic        err_hit;

    assign neg = in_dd_neg ^ in_dr_neg;

    // Divide-by-zero outranks overflow; overflow is only -2^(N-1) / -1,
    // the one case where a positive result has the quotient MSB set.
    always_comb begin
        fix = '0;
        if (in_dr_zero) begin
            fix.quo            = '1;
            fix.rem            = in_dd;
            fix.flags[FLAG_DZ] = 1'b1;
        end else if (!neg && in_quo[N-1]) begin
            fix.quo             = QUO_SAT;
            fix.rem             = '0;
            fix.flags[FLAG_OVF] = 1'b1;
        end else begin
            fix.quo = neg       ? -in_quo : in_quo;
            fix.rem = in_dd_neg ? -in_rem : in_rem;
        end
    end

    nr_div_fifo2 #(
        .W (RES_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (fix),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head)
    );

    assign out_quo = head.quo;
    assign out_rem = head.rem;
    assign out_dz  = head.flags[FLAG_DZ];
    assign out_ovf = head.flags[FLAG_OVF];

    assign accept  = in_valid && in_ready;
    assign err_hit = fix.flags[FLAG_DZ] || fix.flags[FLAG_OVF];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && err_hit && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_nr_div_result_fixup.sv
// Scoreboard bench for nr_div_result_fixup at N=4: driver queues hand-computed
// results on accept, an independent monitor compares on every output handshake.
module tb_nr_div_result_fixup;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_quo;
    logic [N-1:0]     in_rem;
    logic [N-1:0]     in_dd;
    logic             in_dd_neg;
    logic             in_dr_neg;
    logic             in_dr_zero;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_quo;
    logic [N-1:0]     out_rem;
    logic             out_dz;
    logic             out_ovf;
    logic [CNT_W-1:0] err_cnt;

    typedef struct packed {
        logic [N-1:0] quo;
        logic [N-1:0] rem;
        logic         dz;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   exp_err = 0;

    always #5 clk = ~clk;

    nr_div_result_fixup #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_quo     (in_quo),
        .in_rem     (in_rem),
        .in_dd      (in_dd),
        .in_dd_neg  (in_dd_neg),
        .in_dr_neg  (in_dr_neg),
        .in_dr_zero (in_dr_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_quo    (out_quo),
        .out_rem    (out_rem),
        .out_dz     (out_dz),
        .out_ovf    (out_ovf),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: sample 1 time unit after the falling edge; the handshake
    // completes on the following rising edge with these same values.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got quo=%b rem=%b dz=%b ovf=%b with empty scoreboard",
                         out_quo, out_rem, out_dz, out_ovf);
            end else begin
                e = sb.pop_front();
                check("result {quo,rem,dz,ovf}", {22'd0, out_quo, out_rem, out_dz, out_ovf}, {22'd0, e});
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [N-1:0] q, input logic [N-1:0] r, input logic [N-1:0] dd,
                        input logic ddn, input logic drn, input logic drz,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input logic edz, input logic eovf);
        int waited = 0;
        in_quo     = q;
        in_rem     = r;
        in_dd      = dd;
        in_dd_neg  = ddn;
        in_dr_neg  = drn;
        in_dr_zero = drz;
        in_valid   = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles", in_ready, waited);
            in_valid = 1'b0;
            return;
        end
        sb.push_back({eq, er, edz, eovf});
        if ((edz || eovf) && exp_err < 255) exp_err++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_quo     = '0;
        in_rem     = '0;
        in_dd      = '0;
        in_dd_neg  = 1'b0;
        in_dr_neg  = 1'b0;
        in_dr_zero = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset in_ready",  in_ready,  1);
        check("reset out_valid", out_valid, 0);
        check("reset out_quo",   out_quo,   0);
        check("reset out_rem",   out_rem,   0);
        check("reset out_dz",    out_dz,    0);
        check("reset out_ovf",   out_ovf,   0);
        check("reset err_cnt",   err_cnt,   0);

        // 7/2, with one-cycle latency from an empty FIFO
        send(4'd3, 4'd1, 4'd7, 0, 0, 0, 4'b0011, 4'b0001, 0, 0);
        check("latency out_valid", out_valid, 1);
        // -7/2 and 7/-2
        send(4'd3, 4'd1, 4'b1001, 1, 0, 0, 4'b1101, 4'b1111, 0, 0);
        send(4'd3, 4'd1, 4'd7,    0, 1, 0, 4'b1101, 4'b0001, 0, 0);
        // -7/-2: positive quotient, negative remainder
        send(4'd3, 4'd1, 4'b1001, 1, 1, 0, 4'b0011, 4'b1111, 0, 0);
        // -8/1: -(1000) stays 1000, no overflow
        send(4'b1000, 4'd0, 4'b1000, 1, 0, 0, 4'b1000, 4'b0000, 0, 0);
        // -8/-1 saturates
        send(4'b1000, 4'd0, 4'b1000, 1, 1, 0, 4'b0111, 4'b0000, 0, 1);
        check("err_cnt after ovf", err_cnt, 1);
        // 0/-3 gives zero, not a negative zero pattern
        send(4'd0, 4'd0, 4'd0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0);
        // divide by zero, including priority over sign tags and the ovf pattern
        send(4'd0, 4'd0, 4'd5, 0, 0, 1, 4'b1111, 4'b0101, 1, 0);
        send(4'b1000, 4'd2, 4'b1101, 1, 1, 1, 4'b1111, 4'b1101, 1, 0);
        check("err_cnt after dz", err_cnt, 3);

        for (int i = 0; i < 256; i++) begin
            send(4'd0, 4'd0, 4'd5, 0, 0, 1, 4'b1111, 4'b0101, 1, 0);
        end
        check("err_cnt saturated model", err_cnt, exp_err);
        check("err_cnt saturated 255",   err_cnt, 255);

        // Back-pressure: two accepts fill the FIFO, the third is held
        repeat (3) @(negedge clk);
        check("drained out_valid", out_valid, 0);
        out_ready = 1'b0;
        send(4'd1, 4'd0, 4'd1, 0, 0, 0, 4'b0001, 4'b0000, 0, 0);
        send(4'd2, 4'd1, 4'd5, 0, 0, 0, 4'b0010, 4'b0001, 0, 0);
        check("full in_ready",  in_ready,  0);
        check("full out_valid", out_valid, 1);
        check("full head quo",  out_quo,   4'b0001);
        fork
            send(4'd4, 4'd3, 4'b1101, 1, 1, 0, 4'b0100, 4'b1101, 0, 0);
            begin
                repeat (3) @(negedge clk);
                check("held in_ready", in_ready, 0);
                check("held head stable", out_quo, 4'b0001);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check("drain after release", out_valid, 0);

        // Push and pop together at count 1 keep count at 1
        send(4'd1, 4'd1, 4'd3, 0, 0, 0, 4'b0001, 4'b0001, 0, 0);
        send(4'd2, 4'd0, 4'd4, 0, 1, 0, 4'b1110, 4'b0000, 0, 0);
        check("simul in_ready",  in_ready,  1);
        check("simul out_valid", out_valid, 1);
        send(4'd3, 4'd2, 4'b1001, 1, 0, 0, 4'b1101, 4'b1110, 0, 0);
        check("simul2 in_ready",  in_ready,  1);
        check("simul2 out_valid", out_valid, 1);
        @(negedge clk);
        check("simul drained", out_valid, 0);

        // Asynchronous reset with two entries queued
        out_ready = 1'b0;
        send(4'd0, 4'd0, 4'd6, 0, 0, 1, 4'b1111, 4'b0110, 1, 0);
        send(4'd1, 4'd0, 4'd2, 0, 0, 0, 4'b0001, 4'b0000, 0, 0);
        check("pre-reset in_ready", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst in_ready",  in_ready,  1);
        check("async rst err_cnt",   err_cnt,   0);
        check("async rst out_quo",   out_quo,   0);
        sb.delete();
        exp_err = 0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        send(4'd2, 4'd1, 4'b1011, 1, 0, 0, 4'b1110, 4'b1111, 0, 0);
        check("post-reset latency", out_valid, 1);
        check("post-reset err_cnt", err_cnt, exp_err);

        repeat (3) @(negedge clk);
        check("scoreboard empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
